// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_pkg
// Purpose : Shared op encodings, FSM state codes and cycle-count helpers for
//           the iterative multiply/divide unit.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package multdiv_pkg;

  // Operation encodings carried on the op port
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  // Control FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Iterations needed for a multiply: MUL_BITS multiplier bits per cycle
  function automatic int mul_cycles(input int width, input int mul_bits);
    return width / mul_bits;
  endfunction

  // Iterations needed for a restoring divide: one quotient bit per cycle
  function automatic int div_cycles(input int width);
    return width;
  endfunction

  // Counter width able to represent 0..n_max
  function automatic int cnt_width(input int n_max);
    return $clog2(n_max + 1);
  endfunction

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_sign_unit.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_sign_unit
// Purpose : Two independent conditional two's-complement negators. Used as
//           abs() on the operands and as the result sign fix-up.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module multdiv_sign_unit #(
  parameter int W_A = 32,
  parameter int W_B = 32
) (
  input  logic [W_A-1:0] val_a,
  input  logic           neg_a,
  input  logic [W_B-1:0] val_b,
  input  logic           neg_b,
  output logic [W_A-1:0] res_a,
  output logic [W_B-1:0] res_b
);

  // Negate each lane only when its flag is set; the arithmetic wraps mod 2^W,
  // so the most negative value maps to itself, which is the wanted magnitude.
  always_comb begin
    res_a = neg_a ? (-val_a) : val_a;
    res_b = neg_b ? (-val_b) : val_b;
  end

endmodule : multdiv_sign_unit
`default_nettype wire

// File: rtl/multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : multdiv_seq
// Purpose : Iterative multiply/divide unit with valid/ready handshakes, tag
//           pass-through and flush. Multiply is shift-add on magnitudes,
//           divide is restoring; signs are fixed up at completion.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N_MUL = mul_cycles(WIDTH, MUL_BITS);
  localparam int N_DIV = div_cycles(WIDTH);
  localparam int N_MAX = (N_DIV > N_MUL) ? N_DIV : N_MUL;
  localparam int CNT_W = cnt_width(N_MAX);

  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(N_MUL - 1);
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(N_DIV - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_last;
  logic [1:0]         op_q;
  logic               sgn_q;
  logic               neg_p_q;   // product negative
  logic               neg_q_q;   // quotient negative
  logic               neg_r_q;   // remainder negative (dividend sign)
  logic               div0_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   mag;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // {partial product | remainder, multiplier | quotient}
  logic [TAG_W-1:0]   tag_q;

  // --------------------------------------------------------------------------
  // Operand magnitudes and request decode
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             a_neg;
  logic             b_neg;
  logic             req_div;
  logic             req_div0;
  logic             req_ovf;
  logic             accept;

  assign a_neg    = is_signed & operand_a[WIDTH-1];
  assign b_neg    = is_signed & operand_b[WIDTH-1];
  assign req_div  = op[1];
  assign req_div0 = req_div & (operand_b == '0);
  assign req_ovf  = req_div & is_signed & (operand_a == MOST_NEG) & (&operand_b);
  assign accept   = in_valid & in_ready & ~flush;

  multdiv_sign_unit #(
    .W_A (WIDTH),
    .W_B (WIDTH)
  ) u_sign_in (
    .val_a (operand_a),
    .neg_a (a_neg),
    .val_b (operand_b),
    .neg_b (b_neg),
    .res_a (abs_a),
    .res_b (abs_b)
  );

  // --------------------------------------------------------------------------
  // One iteration of multiply or divide on the shared accumulator
  // --------------------------------------------------------------------------
  logic [WIDTH+MUL_BITS-1:0] pp;
  logic [WIDTH+MUL_BITS-1:0] mul_sum;
  logic [2*WIDTH-1:0]        mul_next;
  logic [WIDTH:0]            div_shift;
  logic [WIDTH:0]            div_diff;
  logic [2*WIDTH-1:0]        div_next;
  logic [2*WIDTH-1:0]        acc_next;

  // Compute the next accumulator value for the op in flight
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc[i]) begin
        pp = pp + ({{MUL_BITS{1'b0}}, mag} << i);
      end
    end
    mul_sum  = {{MUL_BITS{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
    mul_next = {mul_sum, acc[WIDTH-1:MUL_BITS]};

    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    if (div0_q) begin
      acc_next = acc;
    end else if (op_q[1]) begin
      acc_next = div_next;
    end else begin
      acc_next = mul_next;
    end
  end

  // --------------------------------------------------------------------------
  // Result sign fix-up and selection
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] fix_in_a;
  logic               fix_neg_a;
  logic [WIDTH-1:0]   fix_in_b;
  logic [2*WIDTH-1:0] fin_a;
  logic [WIDTH-1:0]   fin_b;
  logic [WIDTH-1:0]   res_sel;
  logic               exc_sel;

  assign fix_in_a  = op_q[1] ? {{WIDTH{1'b0}}, acc_next[WIDTH-1:0]} : acc_next;
  assign fix_neg_a = op_q[1] ? neg_q_q : neg_p_q;
  // A divide-by-zero remainder is the dividend, still held in the low half
  assign fix_in_b  = div0_q ? acc_next[WIDTH-1:0] : acc_next[2*WIDTH-1:WIDTH];

  multdiv_sign_unit #(
    .W_A (2*WIDTH),
    .W_B (WIDTH)
  ) u_sign_out (
    .val_a (fix_in_a),
    .neg_a (fix_neg_a),
    .val_b (fix_in_b),
    .neg_b (neg_r_q),
    .res_a (fin_a),
    .res_b (fin_b)
  );

  // Pick the architectural result and exception flag for the completed op
  always_comb begin
    res_sel = '0;
    exc_sel = 1'b0;
    case (op_q)
      OP_MUL: begin
        res_sel = fin_a[WIDTH-1:0];
        if (sgn_q) begin
          exc_sel = (fin_a[2*WIDTH-1:WIDTH] != {WIDTH{fin_a[WIDTH-1]}});
        end else begin
          exc_sel = (fin_a[2*WIDTH-1:WIDTH] != '0);
        end
      end
      OP_MULH: begin
        res_sel = fin_a[2*WIDTH-1:WIDTH];
        exc_sel = 1'b0;
      end
      OP_DIV: begin
        res_sel = div0_q ? {WIDTH{1'b1}} : fin_a[WIDTH-1:0];
        exc_sel = div0_q | ovf_q;
      end
      default: begin
        res_sel = fin_b;
        exc_sel = div0_q | ovf_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM, operand capture, iteration and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cnt_last      <= '0;
      op_q          <= OP_MUL;
      sgn_q         <= 1'b0;
      neg_p_q       <= 1'b0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      div0_q        <= 1'b0;
      ovf_q         <= 1'b0;
      mag           <= '0;
      acc           <= '0;
      tag_q         <= '0;
      out_result    <= '0;
      out_exception <= 1'b0;
      out_tag       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            cnt      <= '0;
            cnt_last <= req_div0 ? '0 : (req_div ? LAST_DIV : LAST_MUL);
            op_q     <= op;
            sgn_q    <= is_signed;
            neg_p_q  <= a_neg ^ b_neg;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            div0_q   <= req_div0;
            ovf_q    <= req_ovf;
            mag      <= req_div ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (req_div ? abs_a : abs_b)};
            tag_q    <= in_tag;
          end
        end
        ST_BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) begin
            state         <= ST_DONE;
            out_result    <= res_sel;
            out_exception <= exc_sel;
            out_tag       <= tag_q;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

endmodule : multdiv_seq
`default_nettype wire

// File: tb/tb_multdiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_multdiv_seq
// Purpose : Self-checking bench for multdiv_seq: vector table through a
//           scoreboard, plus handshake, flush and reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multdiv_seq;
  import multdiv_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, is_signed, flush;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_exception, busy;

  logic        d4_in_valid, d4_in_ready, d4_is_signed, d4_flush;
  logic [1:0]  d4_op;
  logic [31:0] d4_a, d4_b, d4_result;
  logic [4:0]  d4_in_tag, d4_out_tag;
  logic        d4_out_valid, d4_out_ready, d4_exc, d4_busy;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  vec_t vecs[18];

  multdiv_seq #(.WIDTH(32), .MUL_BITS(1), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_signed(is_signed), .operand_a(operand_a), .operand_b(operand_b),
    .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exception(out_exception), .out_tag(out_tag),
    .busy(busy)
  );

  multdiv_seq #(.WIDTH(32), .MUL_BITS(4), .TAG_W(5)) dut4 (
    .clock(clock), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .op(d4_op), .is_signed(d4_is_signed), .operand_a(d4_a), .operand_b(d4_b),
    .in_tag(d4_in_tag), .flush(d4_flush), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .out_result(d4_result), .out_exception(d4_exc),
    .out_tag(d4_out_tag), .busy(d4_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a sequence wedges
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("wait_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Wait for out_valid after an accept tick; compare against scoreboard head
  task automatic collect(input string name);
    int   lat;
    bit   seen;
    exp_t e;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 64; c++) begin
      if (!seen) begin
        tick();
        if (out_valid) begin
          seen = 1'b1;
          lat  = c;
        end
      end
    end
    if (!seen) begin
      chk({name, "_valid_timeout"}, 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({name, "_unexpected_result"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_result"}, 64'(out_result), 64'(e.res));
      chk({name, "_exc"}, 64'(out_exception), 64'(e.exc));
      chk({name, "_tag"}, 64'(out_tag), 64'(e.tag));
      chk({name, "_latency"}, 64'(lat), 64'(e.lat));
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] r, input logic x, input int l);
    exp_t e;
    wait_ready();
    op = o; is_signed = s; operand_a = a; operand_b = b; in_tag = t;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e.res = r; e.exc = x; e.tag = t; e.lat = l;
    sb.push_back(e);
  endtask

  initial begin
    int  cnt_v;
    bit  seen;
    vecs[0]  = '{OP_MUL,  1'b0, 32'd7,        32'd6,        5'h01, 32'd42,       1'b0, 32};
    vecs[1]  = '{OP_MULH, 1'b1, -32'sd3,      32'd5,        5'h02, 32'hFFFFFFFF, 1'b0, 32};
    vecs[2]  = '{OP_MUL,  1'b1, -32'sd3,      32'd5,        5'h03, 32'hFFFFFFF1, 1'b0, 32};
    vecs[3]  = '{OP_MUL,  1'b1, 32'h00010000, 32'h00010000, 5'h04, 32'h00000000, 1'b1, 32};
    vecs[4]  = '{OP_DIV,  1'b1, -32'sd7,      32'd2,        5'h1A, 32'hFFFFFFFD, 1'b0, 32};
    vecs[5]  = '{OP_REM,  1'b1, -32'sd7,      32'd2,        5'h1A, 32'hFFFFFFFF, 1'b0, 32};
    vecs[6]  = '{OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd2,        5'h1A, 32'h7FFFFFFC, 1'b0, 32};
    vecs[7]  = '{OP_DIV,  1'b0, 32'd10,       32'd0,        5'h05, 32'hFFFFFFFF, 1'b1, 1};
    vecs[8]  = '{OP_REM,  1'b0, 32'd10,       32'd0,        5'h06, 32'd10,       1'b1, 1};
    vecs[9]  = '{OP_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 5'h07, 32'h80000000, 1'b1, 32};
    vecs[10] = '{OP_REM,  1'b1, 32'h80000000, 32'hFFFFFFFF, 5'h08, 32'h00000000, 1'b1, 32};
    vecs[11] = '{OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h09, 32'h00000001, 1'b1, 32};
    vecs[12] = '{OP_MULH, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0A, 32'hFFFFFFFE, 1'b0, 32};
    vecs[13] = '{OP_DIV,  1'b1, 32'd7,        -32'sd2,      5'h0B, 32'hFFFFFFFD, 1'b0, 32};
    vecs[14] = '{OP_REM,  1'b1, 32'd7,        -32'sd2,      5'h0C, 32'h00000001, 1'b0, 32};
    vecs[15] = '{OP_MUL,  1'b1, 32'h80000000, 32'd1,        5'h0D, 32'h80000000, 1'b0, 32};
    vecs[16] = '{OP_REM,  1'b1, -32'sd10,     32'd0,        5'h0E, 32'hFFFFFFF6, 1'b1, 1};
    vecs[17] = '{OP_DIV,  1'b0, 32'd100,      32'd7,        5'h0F, 32'd14,       1'b0, 32};

    reset = 1'b0; in_valid = 1'b0; op = OP_MUL; is_signed = 1'b0;
    operand_a = '0; operand_b = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    d4_in_valid = 1'b0; d4_op = OP_MUL; d4_is_signed = 1'b0; d4_a = '0; d4_b = '0;
    d4_in_tag = '0; d4_flush = 1'b0; d4_out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_exc", 64'(out_exception), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);

    // Vector table through the scoreboard
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag,
            vecs[i].res, vecs[i].exc, vecs[i].lat);
      collect($sformatf("vec%0d", i));
    end

    // Four multiplier bits per cycle: 8-cycle multiply
    d4_op = OP_MUL; d4_is_signed = 1'b0; d4_a = 32'd7; d4_b = 32'd6; d4_in_tag = 5'h11;
    d4_in_valid = 1'b1;
    tick();
    d4_in_valid = 1'b0;
    cnt_v = 0; seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!seen) begin
        tick();
        if (d4_out_valid) begin seen = 1'b1; cnt_v = c; end
      end
    end
    chk("mb4_latency", 64'(cnt_v), 64'd8);
    chk("mb4_result", 64'(d4_result), 64'd42);
    chk("mb4_tag", 64'(d4_out_tag), 64'h11);

    // Backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    issue(OP_MUL, 1'b0, 32'd3, 32'd4, 5'h05, 32'd12, 1'b0, 32);
    collect("bp");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold_result%0d", c), 64'(out_result), 64'd12);
      chk($sformatf("bp_hold_in_ready%0d", c), 64'(in_ready), 64'd0);
    end
    chk("bp_hold_tag", 64'(out_tag), 64'h05);
    out_ready = 1'b1;
    op = OP_MUL; is_signed = 1'b0; operand_a = 32'd2; operand_b = 32'd3; in_tag = 5'h06;
    in_valid = 1'b1;
    tick();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_busy", 64'(busy), 64'd1);
    chk("bp_next_in_ready", 64'(in_ready), 64'd0);
    begin
      exp_t e;
      e.res = 32'd6; e.exc = 1'b0; e.tag = 5'h06; e.lat = 32;
      sb.push_back(e);
    end
    collect("bp_next");

    // Flush in IDLE blocks the accept
    tick();
    op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_in_ready", 64'(in_ready), 64'd1);

    // Flush on the fifth busy cycle of a divide
    op = OP_DIV; is_signed = 1'b0; operand_a = 32'd100; operand_b = 32'd7; in_tag = 5'h12;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_busy_no_valid", 64'(seen), 64'd0);

    // Flush in DONE drops the result even with out_ready high
    out_ready = 1'b0;
    op = OP_DIV; is_signed = 1'b0; operand_a = 32'd10; operand_b = 32'd0; in_tag = 5'h13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("flush_done_valid_before", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_valid_after", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Reset on the twelfth busy cycle of a multiply
    op = OP_MUL; is_signed = 1'b0; operand_a = 32'd7; operand_b = 32'd6; in_tag = 5'h14;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", 64'(out_result), 64'd0);
    chk("rst_mid_exc", 64'(out_exception), 64'd0);
    chk("rst_mid_tag", 64'(out_tag), 64'd0);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_stale", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multdiv_seq
`default_nettype wire

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
Parametrised iterative multiply/divide unit, successor to the fixed 32-bit multdiv used in the execute stage. Adds WIDTH/throughput generics, signed and unsigned modes, high-half multiply and remainder ops, and a valid/ready handshake on both sides. Carries a destination tag through the operation and supports pipeline flush. The processor stalls on in_ready/busy and retires through the P/W writeback path using out_tag.

Parameters:
WIDTH, 32, operand/result width; even, >= 8
MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4); WIDTH % MUL_BITS == 0
TAG_W, 5, width of the pass-through destination tag

Ports:
clock  in  1  sole clock; all state changes on rising edge
reset  in  1  synchronous, active-low; sampled on the rising edge of clock
in_valid  in  1  request present
in_ready  out  1  unit can accept; high only in IDLE
op  in  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
operand_a  in  WIDTH  multiplicand / dividend
operand_b  in  WIDTH  multiplier / divisor
in_tag  in  TAG_W  destination tag, returned unchanged
flush  in  1  abandon any in-flight or pending result
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_result  out  WIDTH  result per op
out_exception  out  1  overflow or divide-by-zero (see below)
out_tag  out  TAG_W  tag captured at accept
busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (reset==0 at edge): state IDLE; in_ready=1 after reset releases; out_valid=0, busy=0, out_result=0, out_exception=0, out_tag=0. Reset overrides flush and handshakes. Reset mid-operation discards it silently.
- FSM: IDLE -> BUSY on accept (in_valid & in_ready & ~flush); BUSY -> DONE when the iteration count hits N; DONE -> IDLE on out_valid & out_ready; any state -> IDLE on flush.
- Accept at edge k captures op, is_signed, tag, operand magnitudes and result sign. out_valid rises at edge k+N:
  - N = WIDTH/MUL_BITS for MUL/MULH.
  - N = WIDTH for DIV/REM.
  - N = 1 for divide-by-zero (short-circuit).
- Iteration counter is ceil(log2(N+1)) bits, cleared on accept.
- Multiply: unsigned shift-add on magnitudes into a 2*WIDTH product; MUL_BITS partial products per cycle. Negate the product at completion if is_signed and the operand signs differ.
  - MUL returns product[WIDTH-1:0]. out_exception=1 iff product[2W-1:W] is not the sign-extension of bit W-1 (signed) or is nonzero (unsigned).
  - MULH returns product[2W-1:W]; exception always 0.
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient is negated if is_signed and signs differ; remainder takes the dividend's sign.
- Divide-by-zero (operand_b==0, DIV or REM): DIV returns all ones, REM returns operand_a, out_exception=1.
- Signed overflow (is_signed, a = 100..0, b = all ones): DIV returns 100..0, REM returns 0, out_exception=1. Full N-cycle latency.
- DONE holds out_result/out_exception/out_tag stable while out_ready=0 (backpressure, no timeout).
- in_ready=0 in BUSY and DONE. A result handshake and a new accept never occur in the same cycle; the next accept is possible one cycle after the output handshake.
- flush:
  - In IDLE with in_valid: blocks the accept.
  - In BUSY: aborts; out_valid never rises for that op.
  - In DONE: drops the result, even if out_ready is high the same cycle.
  - in_ready=1 the cycle after.
- After out_valid falls, outputs retain their last values; consumers qualify them with out_valid only.

Decomposition:
- Package multdiv_pkg:
  - op encodings OP_MUL/OP_MULH/OP_DIV/OP_REM
  - state enum IDLE/BUSY/DONE
  - localparam helpers for N and counter width
- One sub-module, multdiv_sign_unit (combinational): operand abs() and conditional result negate. Instantiated once for inputs and once for outputs.
- Datapath, counter and FSM stay in multdiv_seq.

Test Plan:
1. WIDTH=32, MUL_BITS=1, unsigned MUL 7*6, out_ready=1 -> out_result=42, exception 0, out_valid exactly 32 cycles after accept; same op with MUL_BITS=4 -> 8 cycles.
2. Signed MULH -3*5 -> 0xFFFFFFFF; signed MUL -3*5 -> 0xFFFFFFF1, exception 0; signed MUL 0x10000*0x10000 -> 0x00000000, exception 1.
3. Signed DIV -7/2 -> 0xFFFFFFFD; signed REM -7/2 -> 0xFFFFFFFF; unsigned DIV 0xFFFFFFF9/2 -> 0x7FFFFFFC; all 32-cycle latency, out_tag echoes in_tag=0x1A.
4. DIV 10/0 -> 0xFFFFFFFF, exception 1, out_valid 1 cycle after accept; REM 10/0 -> 10, exception 1; signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000, exception 1 after 32 cycles.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; raise out_ready -> handshake, in_ready=1 next cycle, back-to-back MUL accepted.
6. Flush at cycle 5 of a DIV -> no out_valid, in_ready=1 next cycle; reset=0 at cycle 12 of a MUL -> all outputs at reset values, no stale result after release.
